dm_arbiter: RTL

Two-port arbiter and sequencer in front of the 1 KB byte-addressed data memory. Master 0 is the pipeline MEM stage, master 1 is the debug/DMA loader. The block grants one access per cycle, registers it into a single command stage that drives the memory, and returns a registered response with read data or error. It also screens each access for alignment, range and legal encoding before the memory sees it.

---
 rtl/dm_arbiter_if.sv | 21 ++
 rtl/dm_arbiter.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/dm_arbiter_if.sv
// dm_arbiter_if: one master's port on the data-memory arbiter.
//   req, lock, we, re, addr, wdata : request, held by the master until gnt
//   gnt                            : combinational grant, accepted at next rising edge
//   rvalid, err, rdata             : registered one-cycle response
interface dm_arbiter_if;
    logic        req;
    logic        lock;
    logic [1:0]  we;
    logic [2:0]  re;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic        err;
    logic [31:0] rdata;

    modport master (output req, lock, we, re, addr, wdata,
                    input  gnt, rvalid, err, rdata);
    modport slave  (input  req, lock, we, re, addr, wdata,
                    output gnt, rvalid, err, rdata);
endinterface

// File: rtl/dm_arbiter.sv
// dm_arbiter: two-master arbiter and one-deep command stage in front of the
// byte-addressed data memory. m0 = pipeline MEM stage, m1 = debug/DMA loader.
//   clk, rstn      : clock, asynchronous active-low reset
//   m0, m1         : master request/response ports (dm_arbiter_if.slave)
//   mem_we/re      : store/load code to memory (zero when idle or rejected)
//   mem_addr/din   : memory address and write data
//   mem_dout       : combinational load data from memory

// Screens one request: illegal encoding, misalignment, out of range.
module dm_arb_chk #(
    parameter int unsigned DM_BYTES = 1024
) (
    input  logic [1:0]  we,
    input  logic [2:0]  re,
    input  logic [31:0] addr,
    output logic        err
);
    localparam logic [32:0] LIMIT = 33'(DM_BYTES);

    logic [2:0]  size;
    logic        mis;
    logic [32:0] last;

    always_comb begin
        size = 3'd0;
        if (we != 2'b00) begin
            case (we)
                2'b01:   size = 3'd4;
                2'b10:   size = 3'd2;
                default: size = 3'd1;
            endcase
        end else begin
            case (re)
                3'b001:         size = 3'd4;
                3'b010, 3'b011: size = 3'd2;
                3'b100, 3'b101: size = 3'd1;
                default:        size = 3'd0;
            endcase
        end
        case (size)
            3'd4:    mis = (addr[1:0] != 2'b00);
            3'd2:    mis = addr[0];
            default: mis = 1'b0;
        endcase
        // 33-bit sum so addresses near 2^32 cannot wrap back into range
        last = {1'b0, addr} + {30'd0, size} - 33'd1;
        err  = ((we != 2'b00) && (re != 3'b000)) || (re[2:1] == 2'b11) || mis ||
               ((size != 3'd0) && (last >= LIMIT));
    end
endmodule

module dm_arbiter #(
    parameter int unsigned DM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        rstn,
    dm_arbiter_if.slave m0,
    dm_arbiter_if.slave m1,
    output logic [1:0]  mem_we,
    output logic [2:0]  mem_re,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    input  logic [31:0] mem_dout
);
    localparam int NUM_M = 2;

    typedef struct packed {
        logic        own;
        logic [1:0]  we;
        logic [2:0]  re;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
    } cmd_t;

    typedef struct packed {
        logic        own;
        logic        err;
        logic [31:0] rdata;
    } rsp_t;

    logic [NUM_M-1:0]        req, lock, gnt, chk_err, rv;
    logic [NUM_M-1:0][1:0]   we;
    logic [NUM_M-1:0][2:0]   re;
    logic [NUM_M-1:0][31:0]  addr, wdata;

    assign req   = {m1.req,   m0.req};
    assign lock  = {m1.lock,  m0.lock};
    assign we    = {m1.we,    m0.we};
    assign re    = {m1.re,    m0.re};
    assign addr  = {m1.addr,  m0.addr};
    assign wdata = {m1.wdata, m0.wdata};

    for (genvar i = 0; i < NUM_M; i++) begin : g_chk
        dm_arb_chk #(.DM_BYTES(DM_BYTES)) u_chk (
            .we   (we[i]),
            .re   (re[i]),
            .addr (addr[i]),
            .err  (chk_err[i])
        );
    end

    // vld_pipe[0]: command stage occupied, vld_pipe[1]: response valid
    logic [1:0] vld_pipe_q, vld_pipe_d;
    logic       prio_q, prio_d, gid;
    cmd_t       cmd_q, cmd_d;
    rsp_t       rsp_q, rsp_d;

    always_comb begin
        gnt = '0;
        if (rstn && req[0] && (!req[1] || !prio_q)) gnt[0] = 1'b1;
        else if (rstn && req[1])                    gnt[1] = 1'b1;
        gid = gnt[1];

        // a locked grant keeps priority on its owner, so the owner wins
        // every contended cycle until it drops req
        prio_d = prio_q;
        if (|gnt) prio_d = lock[gid] ? gid : ~gid;

        vld_pipe_d = {vld_pipe_q[0], |gnt};

        cmd_d = '0;
        if (|gnt) begin
            cmd_d.own   = gid;
            cmd_d.we    = we[gid];
            cmd_d.re    = re[gid];
            cmd_d.addr  = addr[gid];
            cmd_d.wdata = wdata[gid];
            cmd_d.err   = chk_err[gid];
        end

        rsp_d.own   = cmd_q.own;
        rsp_d.err   = cmd_q.err;
        rsp_d.rdata = (vld_pipe_q[0] && !cmd_q.err && (cmd_q.re != 3'b000)) ? mem_dout : '0;
    end

    // rejected commands keep the memory idle
    always_comb begin
        mem_we   = '0;
        mem_re   = '0;
        mem_addr = '0;
        mem_din  = '0;
        if (vld_pipe_q[0]) begin
            mem_addr = cmd_q.addr;
            mem_din  = cmd_q.wdata;
            if (!cmd_q.err) begin
                mem_we = cmd_q.we;
                mem_re = cmd_q.re;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            prio_q     <= 1'b0;
            vld_pipe_q <= '0;
            cmd_q      <= '0;
            rsp_q      <= '0;
        end else begin
            prio_q     <= prio_d;
            vld_pipe_q <= vld_pipe_d;
            cmd_q      <= cmd_d;
            rsp_q      <= rsp_d;
        end
    end

    assign rv[0] = vld_pipe_q[1] && !rsp_q.own;
    assign rv[1] = vld_pipe_q[1] &&  rsp_q.own;

    assign m0.gnt    = gnt[0];
    assign m0.rvalid = rv[0];
    assign m0.err    = rv[0] && rsp_q.err;
    assign m0.rdata  = rv[0] ? rsp_q.rdata : '0;
    assign m1.gnt    = gnt[1];
    assign m1.rvalid = rv[1];
    assign m1.err    = rv[1] && rsp_q.err;
    assign m1.rdata  = rv[1] ? rsp_q.rdata : '0;
endmodule
